// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-entry byte FIFO that sequences queued bytes into the
// UART transmitter's Tx_WR/Tx_DATA/Tx_BUSY handshake, recovering from a silent transmitter by timeout.
module uart_tx_feeder #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AW          = 3,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          flush,
    input  logic          drain_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          tx_drop,
    input  logic          Tx_BUSY,
    output logic          Tx_WR,
    output logic [7:0]    Tx_DATA
);
    localparam int unsigned   TW         = $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    logic [7:0]    mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          overflow_q, overflow_d, tx_drop_q, tx_drop_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_wr_q, tx_wr_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          push_ok, pop;

    // full is the registered flag, so a push is refused even if a pop frees a slot this cycle
    assign push_ok = push & ~full_q & ~flush;
    assign pop     = (state_q == ST_IDLE) & ~empty_q & drain_en & ~Tx_BUSY & ~flush;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        tx_data_d  = tx_data_q;
        tx_wr_d    = 1'b0;
        tx_drop_d  = tx_drop_q;
        overflow_d = overflow_q | (push & full_q);
        wr_d       = push_ok ? wr_q + AW'(1) : wr_q;
        rd_d       = pop ? rd_q + AW'(1) : rd_q;
        level_d    = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_q];
                    tx_wr_d   = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (Tx_BUSY) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    tx_drop_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!Tx_BUSY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // flush clears the queue and sticky flags but leaves an in-flight byte alone
        if (flush) begin
            rd_d       = '0;
            wr_d       = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            tx_drop_d  = 1'b0;
        end

        full_d  = (level_d == LEVEL_FULL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            tx_drop_q  <= 1'b0;
            timer_q    <= '0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            tx_drop_q  <= tx_drop_d;
            timer_q    <= timer_d;
            tx_wr_q    <= tx_wr_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign tx_drop  = tx_drop_q;
    assign Tx_WR    = tx_wr_q;
    assign Tx_DATA  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed scenarios plus randomized gaps, checked
// against an occupancy-count / expected-byte-queue model and a transmitter model.
module tb_uart_tx_feeder;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic [7:0] push_data;
    logic       flush;
    logic       drain_en;
    logic       full, empty, overflow, tx_drop;
    logic [3:0] level;
    logic       Tx_BUSY = 1'b0;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;

    uart_tx_feeder #(.DEPTH(8), .AW(3), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data),
        .flush(flush), .drain_en(drain_en), .full(full), .empty(empty),
        .level(level), .overflow(overflow), .tx_drop(tx_drop),
        .Tx_BUSY(Tx_BUSY), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for busy_len cycles starting one cycle after Tx_WR
    logic [7:0] got_q[$];
    int         wr_pulses    = 0;
    int         dbl_cnt      = 0;
    int         unstable_cnt = 0;
    int         busy_left    = 0;
    bit         pend         = 1'b0;
    bit         prev_wr      = 1'b0;
    logic [7:0] last_byte    = 8'h00;

    bit xmit_en  = 1'b1;
    int busy_len = 20;

    always @(posedge clk) begin
        #1;
        if (reset !== 1'b1 || !xmit_en) begin
            pend      = 1'b0;
            busy_left = 0;
            Tx_BUSY   = 1'b0;
        end else if (pend) begin
            pend      = 1'b0;
            busy_left = busy_len;
            Tx_BUSY   = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) Tx_BUSY = 1'b0;
        end
        if (Tx_BUSY && Tx_DATA !== last_byte) unstable_cnt++;
        if (Tx_WR === 1'b1) begin
            if (prev_wr) dbl_cnt++;
            got_q.push_back(Tx_DATA);
            last_byte = Tx_DATA;
            wr_pulses++;
            if (xmit_en && reset === 1'b1) pend = 1'b1;
        end
        prev_wr = (Tx_WR === 1'b1);
    end

    int         n_asserts = 0;
    int         n_fail    = 0;
    int         n_acc     = 0;
    int         wr_base   = 0;
    int         chk_idx   = 0;
    logic [7:0] exp_q[$];

    function automatic int model_level();
        return n_acc - (wr_pulses - wr_base);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc;
        acc       = (model_level() < DEPTH);
        push      = 1'b1;
        push_data = b;
        @(negedge clk);
        push = 1'b0;
        if (acc) begin
            n_acc++;
            exp_q.push_back(b);
        end
    endtask

    // Bytes still queued are discarded; anything already handed over stays expected
    task automatic model_clear();
        n_acc   = 0;
        wr_base = wr_pulses;
        while (exp_q.size() > wr_pulses) void'(exp_q.pop_back());
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = chk_idx; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        chk_idx = got_q.size();
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("level_model", level, model_level());
        chk("level_le_depth", level <= 4'd8, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int t;
        int gap;
        reset = 1'b0; push = 1'b0; push_data = 8'h00; flush = 1'b0; drain_en = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_tx_wr", Tx_WR, 0);
        chk("rst_tx_data", Tx_DATA, 8'h00);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_tx_drop", tx_drop, 0);

        // Message: three back-to-back pushes
        xmit_en = 1'b1; busy_len = 20;
        base = wr_pulses;
        push_byte(8'h55);
        chk("msg_empty_after_push", empty, 0);
        chk("msg_level_after_push", level, 1);
        push_byte(8'hA3);
        chk("msg_first_wr", Tx_WR, 1);
        chk("msg_first_data", Tx_DATA, 8'h55);
        chk("msg_level_2nd", level, 1);
        push_byte(8'h0F);
        chk("msg_wr_one_cycle", Tx_WR, 0);
        chk("msg_level_3rd", level, 2);
        for (t = 0; t < 300 && !(got_q.size() == exp_q.size() && Tx_BUSY === 1'b0 && level === 4'd0); t++)
            @(negedge clk);
        chk("msg_drained", t < 300, 1);
        chk("msg_pulses", wr_pulses - base, 3);
        chk("msg_byte0", got_q[base], 8'h55);
        chk("msg_byte1", got_q[base + 1], 8'hA3);
        chk("msg_byte2", got_q[base + 2], 8'h0F);
        chk("msg_level_end", level, 0);
        check_stream("msg");

        // Fill and overflow with draining held off
        repeat (3) @(negedge clk);
        busy_len = 2; drain_en = 1'b0;
        base = wr_pulses;
        for (int i = 0; i < 9; i++) begin
            push_byte(8'h10 + 8'(i));
            if (i == 7) begin
                chk("fill_full8", full, 1);
                chk("fill_level8", level, 8);
                chk("fill_no_ovf_yet", overflow, 0);
            end
        end
        chk("ovf_set", overflow, 1);
        chk("ovf_level", level, 8);
        chk("ovf_full", full, 1);
        chk("ovf_no_tx", wr_pulses - base, 0);
        drain_en = 1'b1;
        for (t = 0; t < 500 && !(wr_pulses - base == 8 && level === 4'd0); t++)
            @(negedge clk);
        repeat (30) @(negedge clk);
        chk("ovf_drain_pulses", wr_pulses - base, 8);
        chk("ovf_sticky", overflow, 1);
        check_stream("fill");
        do_flush();
        chk("flush_clears_ovf", overflow, 0);

        // Wrap-around with randomized gaps and transmitter speed
        busy_len = $urandom_range(1, 6);
        for (int k = 0; k < 20; k++) begin
            gap = $urandom_range(0, 4);
            for (int g = 0; g < gap; g++) idle_cycle();
            for (int w = 0; w < 200 && model_level() >= DEPTH; w++) idle_cycle();
            push_byte(8'(k));
            chk("wrap_level_model", level, model_level());
        end
        for (t = 0; t < 2000 && !(got_q.size() == exp_q.size() && level === 4'd0 && Tx_BUSY === 1'b0); t++)
            idle_cycle();
        chk("wrap_drained", t < 2000, 1);
        check_stream("wrap");

        // ACK timeout with a transmitter that never goes busy
        repeat (3) @(negedge clk);
        xmit_en = 1'b0;
        base = wr_pulses;
        push_byte(8'h7E);
        for (t = 0; t < 10 && Tx_WR !== 1'b1; t++) @(negedge clk);
        chk("to_wr_seen", Tx_WR, 1);
        chk("to_wr_data", Tx_DATA, 8'h7E);
        repeat (15) @(negedge clk);
        chk("to_drop_not_early", tx_drop, 0);
        @(negedge clk);
        chk("to_drop_set", tx_drop, 1);
        chk("to_single_pulse", wr_pulses - base, 1);
        push_byte(8'h81);
        for (t = 0; t < 10 && Tx_WR !== 1'b1; t++) @(negedge clk);
        chk("to_next_wr", Tx_WR, 1);
        chk("to_next_data", Tx_DATA, 8'h81);
        repeat (20) @(negedge clk);
        chk("to_drop_sticky", tx_drop, 1);
        check_stream("timeout");
        do_flush();
        chk("flush_clears_drop", tx_drop, 0);

        // Flush with five bytes queued while a byte is in flight
        xmit_en = 1'b1; busy_len = 20;
        repeat (3) @(negedge clk);
        base = wr_pulses;
        for (int i = 0; i < 6; i++) push_byte(8'h30 + 8'(i));
        for (t = 0; t < 10 && Tx_BUSY !== 1'b1; t++) @(negedge clk);
        chk("fl_pre_level", level, 5);
        do_flush();
        chk("fl_level", level, 0);
        chk("fl_empty", empty, 1);
        chk("fl_full", full, 0);
        for (t = 0; t < 40 && Tx_BUSY !== 1'b0; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("fl_inflight_only", wr_pulses - base, 1);
        chk("fl_inflight_byte", got_q[base], 8'h30);
        check_stream("flush");

        // Asynchronous reset while waiting for the transmitter to finish
        push_byte(8'h99);
        push_byte(8'h9A);
        for (t = 0; t < 10 && Tx_BUSY !== 1'b1; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rs_pre_level", level, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_async_wr", Tx_WR, 0);
        chk("rs_async_empty", empty, 1);
        chk("rs_async_level", level, 0);
        chk("rs_async_data", Tx_DATA, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        base = wr_pulses;
        repeat (40) @(negedge clk);
        chk("rs_queue_discarded", wr_pulses - base, 0);
        chk("rs_level_end", level, 0);
        check_stream("reset");

        chk("no_double_pulse", dbl_cnt, 0);
        chk("data_stable_busy", unstable_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
